// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Bundles the decode/memory handshake and the stall/flush
//               controls exchanged between the pipeline and pipeline_ctrl.
//               master : pipeline side (drives op/op_valid/mem_ready/resume)
//               slave  : controller side (drives stall/stall_pm/pc_en/flush/
//                        halted and, with STALL_CNT_EN, stall_cnt)
//               Optional feature macro: STALL_CNT_EN adds stall_cnt[15:0].
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if;
    logic [5:0]  op;         // opcode currently in decode
    logic        op_valid;   // op is a real instruction, not a bubble
    logic        mem_ready;  // outstanding load has completed
    logic        resume;     // one-cycle pulse that releases HALT
    logic        stall;      // freeze PC/IF/ID this cycle
    logic        stall_pm;   // stall delayed one cycle for program memory
    logic        pc_en;      // inverse of stall
    logic        flush;      // squash wrong-path fetch
    logic        halted;     // registered HALT indicator
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;  // saturating count of stalled cycles

    modport master (
        output op, op_valid, mem_ready, resume,
        input  stall, stall_pm, pc_en, flush, halted, stall_cnt
    );
    modport slave (
        input  op, op_valid, mem_ready, resume,
        output stall, stall_pm, pc_en, flush, halted, stall_cnt
    );
`else
    modport master (
        output op, op_valid, mem_ready, resume,
        input  stall, stall_pm, pc_en, flush, halted
    );
    modport slave (
        input  op, op_valid, mem_ready, resume,
        output stall, stall_pm, pc_en, flush, halted
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Pipeline hazard controller. Decodes the op in decode and
//               stalls the front end for loads (until mem_ready), jumps
//               (JMP_FLUSH cycles with flush) and HLT (until resume).
// Ports       : clk    - system clock, rising edge
//               reset  - asynchronous, active-low reset
//               bus    - pipeline_ctrl_if.slave (op, op_valid, mem_ready,
//                        resume in; stall, stall_pm, pc_en, flush, halted
//                        out; stall_cnt out when STALL_CNT_EN is defined)
// Parameters  : JMP_FLUSH - total jump stall cycles incl. detect, 1..7
// Macro       : STALL_CNT_EN - adds the saturating stall_cnt[15:0] output
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int JMP_FLUSH = 2
) (
    input  wire logic      clk,
    input  wire logic      reset,
    pipeline_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        JFLUSH    = 2'd2,
        HALT      = 2'd3
    } state_t;

    localparam logic [5:0] C_OP_HLT  = 6'h11;
    localparam logic [5:0] C_OP_LOAD = 6'h14;
    // Detect cycle and the final JFLUSH cycle both count toward JMP_FLUSH,
    // so the counter starts at JMP_FLUSH-2 (unused when JMP_FLUSH is 1).
    localparam int         C_JMP_INIT = (JMP_FLUSH >= 2) ? (JMP_FLUSH - 2) : 0;
    localparam logic [2:0] C_JCNT_INIT = 3'(C_JMP_INIT);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_jcnt;
    logic [2:0] w_jcnt_next;
    logic       r_stall_pm;
    logic       r_halted;
    logic       w_stall;
    logic       w_flush;

    logic       w_is_hlt;
    logic       w_is_load;
    logic       w_is_jump;

    assign w_is_hlt  = bus.op_valid && (bus.op == C_OP_HLT);
    assign w_is_load = bus.op_valid && (bus.op == C_OP_LOAD);
    assign w_is_jump = bus.op_valid && (bus.op[5:2] == 4'b0111);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= RUN;
            r_jcnt     <= 3'd0;
            r_stall_pm <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_jcnt     <= w_jcnt_next;
            r_stall_pm <= w_stall;
            r_halted   <= (w_next_state == HALT);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_jcnt_next  = r_jcnt;
        w_stall      = 1'b0;
        w_flush      = 1'b0;

        case (r_state)
            RUN: begin
                if (w_is_load) begin
                    // mem_ready is not looked at here: a load always costs
                    // at least this one cycle.
                    w_stall      = 1'b1;
                    w_next_state = LOAD_WAIT;
                end else if (w_is_jump) begin
                    w_stall = 1'b1;
                    w_flush = 1'b1;
                    if (JMP_FLUSH == 1) begin
                        w_next_state = RUN;
                    end else begin
                        w_next_state = JFLUSH;
                        w_jcnt_next  = C_JCNT_INIT;
                    end
                end else if (w_is_hlt) begin
                    w_stall      = 1'b1;
                    w_next_state = HALT;
                end
            end

            LOAD_WAIT: begin
                w_stall = ~bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next_state = RUN;
                end
            end

            JFLUSH: begin
                w_stall = 1'b1;
                w_flush = 1'b1;
                if (r_jcnt == 3'd0) begin
                    w_next_state = RUN;
                end else begin
                    w_jcnt_next = r_jcnt - 3'd1;
                end
            end

            HALT: begin
                w_stall = ~bus.resume;
                if (bus.resume) begin
                    w_next_state = RUN;
                end
            end

            default: begin
                w_next_state = RUN;
            end
        endcase

        // While held in reset the front end must run freely whatever op is
        // sitting in decode.
        if (!reset) begin
            w_stall = 1'b0;
            w_flush = 1'b0;
        end
    end

    assign bus.stall    = w_stall;
    assign bus.flush    = w_flush;
    assign bus.pc_en    = ~w_stall;
    assign bus.stall_pm = r_stall_pm;
    assign bus.halted   = r_halted;

`ifdef STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. A cycle-level
//               behavioural model (owed jump cycles, pending load, halt flag)
//               is compared against the DUT on every falling edge; directed
//               sequences pin the model with literal expectations, followed
//               by randomized traffic. Macro STALL_CNT_EN enables the
//               stall_cnt checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int JMP_FLUSH = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    pipeline_ctrl_if bus_if ();

    pipeline_ctrl #(.JMP_FLUSH(JMP_FLUSH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_jleft      = 0;     // jump stall cycles still owed after this one
    bit m_load       = 1'b0;  // waiting for memory
    bit m_halt       = 1'b0;  // halted
    bit m_prev_stall = 1'b0;

    function automatic bit is_jump(input logic [5:0] o);
        return (o >= 6'h1C) && (o <= 6'h1F);
    endfunction

    function automatic bit is_stall_op(input logic [5:0] o);
        return is_jump(o) || (o == 6'h14) || (o == 6'h11);
    endfunction

    function automatic bit model_stall();
        if (!reset)      return 1'b0;
        if (m_jleft > 0) return 1'b1;
        if (m_load)      return !bus_if.mem_ready;
        if (m_halt)      return !bus_if.resume;
        return bus_if.op_valid && is_stall_op(bus_if.op);
    endfunction

    function automatic bit model_flush();
        if (!reset)      return 1'b0;
        if (m_jleft > 0) return 1'b1;
        if (m_load || m_halt) return 1'b0;
        return bus_if.op_valid && is_jump(bus_if.op);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_jleft      <= 0;
            m_load       <= 1'b0;
            m_halt       <= 1'b0;
            m_prev_stall <= 1'b0;
        end else begin
            m_prev_stall <= model_stall();
            if (m_jleft > 0) begin
                m_jleft <= m_jleft - 1;
            end else if (m_load) begin
                m_load <= !bus_if.mem_ready;
            end else if (m_halt) begin
                m_halt <= !bus_if.resume;
            end else if (bus_if.op_valid) begin
                if (is_jump(bus_if.op))     m_jleft <= JMP_FLUSH - 1;
                else if (bus_if.op == 6'h14) m_load <= 1'b1;
                else if (bus_if.op == 6'h11) m_halt <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("m_stall",    16'(bus_if.stall),    16'(model_stall()));
        chk("m_flush",    16'(bus_if.flush),    16'(model_flush()));
        chk("m_pc_en",    16'(bus_if.pc_en),    16'(!model_stall()));
        chk("m_stall_pm", 16'(bus_if.stall_pm), 16'(m_prev_stall));
        chk("m_halted",   16'(bus_if.halted),   16'(m_halt));
    end

    task automatic drv(input logic [5:0] o, input logic v, input logic mr, input logic rs);
        @(posedge clk);
        #1;
        bus_if.op        = o;
        bus_if.op_valid  = v;
        bus_if.mem_ready = mr;
        bus_if.resume    = rs;
        @(negedge clk);
    endtask

    task automatic set_reset(input logic r, input logic [5:0] o, input logic v);
        @(posedge clk);
        #1;
        reset           = r;
        bus_if.op       = o;
        bus_if.op_valid = v;
        bus_if.mem_ready = 1'b0;
        bus_if.resume   = 1'b0;
        @(negedge clk);
    endtask

    task automatic summary_and_finish();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired at t=%0t", $time);
        summary_and_finish();
    end

    initial begin
        bus_if.op        = 6'h1C;
        bus_if.op_valid  = 1'b1;
        bus_if.mem_ready = 1'b0;
        bus_if.resume    = 1'b0;
        #1 reset = 1'b0;

        // Reset state: outputs forced idle even with a jump in decode
        @(negedge clk);
        chk("rst_stall",    16'(bus_if.stall),    16'd0);
        chk("rst_flush",    16'(bus_if.flush),    16'd0);
        chk("rst_pc_en",    16'(bus_if.pc_en),    16'd1);
        chk("rst_stall_pm", 16'(bus_if.stall_pm), 16'd0);
        chk("rst_halted",   16'(bus_if.halted),   16'd0);
        set_reset(1'b1, 6'h00, 1'b0);

        // Jump: two stall/flush cycles, stall_pm on cycles 2-3
        drv(6'h1C, 1, 0, 0);
        chk("j1_stall", 16'(bus_if.stall), 16'd1);
        chk("j1_flush", 16'(bus_if.flush), 16'd1);
        chk("j1_pm",    16'(bus_if.stall_pm), 16'd0);
        drv(6'h1C, 1, 0, 0);
        chk("j2_stall", 16'(bus_if.stall), 16'd1);
        chk("j2_flush", 16'(bus_if.flush), 16'd1);
        chk("j2_pm",    16'(bus_if.stall_pm), 16'd1);
        drv(6'h00, 1, 0, 0);
        chk("j3_stall", 16'(bus_if.stall), 16'd0);
        chk("j3_flush", 16'(bus_if.flush), 16'd0);
        chk("j3_pm",    16'(bus_if.stall_pm), 16'd1);
        drv(6'h00, 0, 0, 0);
        chk("j4_pm",    16'(bus_if.stall_pm), 16'd0);

        // Load: detect ignores mem_ready, three waits, then ready
        drv(6'h14, 1, 1, 0);
        chk("l_det", 16'(bus_if.stall), 16'd1);
        for (int i = 0; i < 3; i++) begin
            drv(6'h14, 1, 0, 0);
            chk("l_wait", 16'(bus_if.stall), 16'd1);
        end
        drv(6'h14, 1, 1, 0);
        chk("l_done", 16'(bus_if.stall), 16'd0);
        drv(6'h00, 1, 0, 0);
        chk("l_run",  16'(bus_if.stall), 16'd0);

        // Halt: 20 held cycles, then resume
        drv(6'h11, 1, 0, 0);
        chk("h_det_stall",  16'(bus_if.stall),  16'd1);
        chk("h_det_halted", 16'(bus_if.halted), 16'd0);
        for (int i = 0; i < 20; i++) begin
            drv(6'($urandom), 1, 1'($urandom), 0);
            chk("h_hold_stall",  16'(bus_if.stall),  16'd1);
            chk("h_hold_halted", 16'(bus_if.halted), 16'd1);
        end
        drv(6'h11, 1, 0, 1);
        chk("h_res_stall",  16'(bus_if.stall),  16'd0);
        chk("h_res_halted", 16'(bus_if.halted), 16'd1);
        drv(6'h00, 1, 0, 0);
        chk("h_out_halted", 16'(bus_if.halted), 16'd0);

        // Bubbles, other ops, stray resume
        drv(6'h14, 0, 0, 0);
        chk("b_bubble", 16'(bus_if.stall), 16'd0);
        drv(6'h00, 1, 0, 0);
        chk("b_op00",   16'(bus_if.stall), 16'd0);
        drv(6'h00, 1, 0, 1);
        chk("b_resume", 16'(bus_if.stall), 16'd0);
        drv(6'h00, 1, 0, 0);
        chk("b_resume_halted", 16'(bus_if.halted), 16'd0);

        // Reset during JFLUSH, then a full jump afterwards
        drv(6'h1F, 1, 0, 0);
        chk("rj_det", 16'(bus_if.stall), 16'd1);
        set_reset(1'b0, 6'h1F, 1'b1);
        chk("rj_stall",  16'(bus_if.stall),  16'd0);
        chk("rj_flush",  16'(bus_if.flush),  16'd0);
        chk("rj_halted", 16'(bus_if.halted), 16'd0);
        set_reset(1'b1, 6'h1C, 1'b1);
        chk("rj_re1", 16'(bus_if.stall), 16'd1);
        drv(6'h1C, 1, 0, 0);
        chk("rj_re2", 16'(bus_if.stall), 16'd1);
        drv(6'h00, 1, 0, 0);
        chk("rj_re3", 16'(bus_if.stall), 16'd0);

        // Reset during LOAD_WAIT: afterwards mem_ready low must not stall
        drv(6'h14, 1, 0, 0);
        drv(6'h14, 1, 0, 0);
        chk("rl_wait", 16'(bus_if.stall), 16'd1);
        set_reset(1'b0, 6'h14, 1'b1);
        chk("rl_stall", 16'(bus_if.stall), 16'd0);
        set_reset(1'b1, 6'h00, 1'b1);
        chk("rl_run",   16'(bus_if.stall), 16'd0);

        // Reset during HALT
        drv(6'h11, 1, 0, 0);
        drv(6'h00, 1, 0, 0);
        chk("rh_halted", 16'(bus_if.halted), 16'd1);
        set_reset(1'b0, 6'h00, 1'b1);
        chk("rh_rst_halted", 16'(bus_if.halted), 16'd0);
        set_reset(1'b1, 6'h00, 1'b1);
        chk("rh_run", 16'(bus_if.stall), 16'd0);

`ifdef STALL_CNT_EN
        set_reset(1'b0, 6'h00, 1'b0);
        chk("cnt_rst", bus_if.stall_cnt, 16'd0);
        set_reset(1'b1, 6'h1C, 1'b1);
        drv(6'h1C, 1, 0, 0);
        drv(6'h14, 1, 0, 0);
        for (int i = 0; i < 3; i++) drv(6'h14, 1, 0, 0);
        drv(6'h00, 1, 1, 0);
        chk("cnt_six", bus_if.stall_cnt, 16'd6);
        @(posedge clk);
        #1;
        force dut.r_stall_cnt = 16'hFFFE;
        bus_if.op = 6'h1C;
        bus_if.op_valid = 1'b1;
        @(negedge clk);
        release dut.r_stall_cnt;
        drv(6'h1C, 1, 0, 0);
        drv(6'h14, 1, 0, 0);
        drv(6'h00, 1, 1, 0);
        chk("cnt_sat", bus_if.stall_cnt, 16'hFFFF);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int sel;
            @(posedge clk);
            #1;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    bus_if.op = 6'h1C + 6'($urandom_range(0, 3));
                2, 3:    bus_if.op = 6'h14;
                4:       bus_if.op = 6'h11;
                default: bus_if.op = 6'($urandom);
            endcase
            bus_if.op_valid  = ($urandom_range(0, 9) < 8);
            bus_if.mem_ready = ($urandom_range(0, 9) < 4);
            bus_if.resume    = ($urandom_range(0, 9) < 2);
            reset            = ($urandom_range(0, 149) != 0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        summary_and_finish();
    end

endmodule
`default_nettype wire
